nonce_sweep_ctrl: RTL

Sequencing controller for the double-SHA-256 miner datapath. It sweeps a 32-bit nonce range over a fixed 608-bit header prefix and restarts the miner once per nonce. It compares each 256-bit result against a target and reports the first winning nonce, range exhaustion, or a miner timeout. It sits between the host/config logic and a single miner instance.

---
 rtl/nonce_sweep_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: steps a double-SHA-256 miner through a 32-bit nonce range
// over a fixed 608-bit header prefix. It stops on the first hash <= target,
// when the range is exhausted, or when the miner hangs.
// Optional build macro NONCE_SWEEP_HASHCNT_EN adds a saturating hash_count output.
module nonce_sweep_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [607:0] header_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic [639:0] miner_block,
    output logic         miner_rst,
    input  logic [255:0] miner_hashed,
    input  logic         miner_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout_err,
    output logic [31:0]  nonce_out,
    output logic [255:0] hash_out
`ifdef NONCE_SWEEP_HASHCNT_EN
    ,
    output logic [31:0]  hash_count
`endif
);

    localparam int unsigned HDR_W   = 608;
    localparam int unsigned NONCE_W = 32;
    localparam int unsigned HASH_W  = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_WAIT,
        S_CHECK,
        S_FOUND,
        S_EXHAUST,
        S_ERR
    } state_t;

    state_t               state;
    logic [HDR_W-1:0]     header_q;
    logic [NONCE_W-1:0]   nonce_cur;
    logic [NONCE_W-1:0]   end_q;
    logic [HASH_W-1:0]    target_q;
    logic [HASH_W-1:0]    hash_q;
    logic [CNT_W-1:0]     wd_cnt;
    logic [NONCE_W-1:0]   nonce_nxt;

    // Byte order the miner expects for the nonce word of the block.
    function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

    assign nonce_nxt = nonce_cur + NONCE_W'(1);

    // Sweep sequencer: one state register, all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            header_q    <= '0;
            nonce_cur   <= '0;
            end_q       <= '0;
            target_q    <= '0;
            hash_q      <= '0;
            wd_cnt      <= '0;
            miner_block <= '0;
            miner_rst   <= 1'b1;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            nonce_out   <= '0;
            hash_out    <= '0;
`ifdef NONCE_SWEEP_HASHCNT_EN
            hash_count  <= '0;
`endif
        end else begin
            case (state)
                S_KICK: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        miner_rst <= 1'b1;
                    end else begin
                        state     <= S_WAIT;
                        wd_cnt    <= '0;
                        miner_rst <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        miner_rst <= 1'b1;
                    end else if ((wd_cnt != '0) && miner_done) begin
                        // First WAIT cycle is blanked: a stale done from the previous nonce is ignored.
                        hash_q    <= miner_hashed;
                        state     <= S_CHECK;
                        miner_rst <= 1'b1;
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= S_ERR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        miner_rst   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end

                S_CHECK: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
`ifdef NONCE_SWEEP_HASHCNT_EN
                        if (hash_count != '1) begin
                            hash_count <= hash_count + 32'(1);
                        end
`endif
                        if (hash_q <= target_q) begin
                            state     <= S_FOUND;
                            found     <= 1'b1;
                            busy      <= 1'b0;
                            nonce_out <= nonce_cur;
                            hash_out  <= hash_q;
                        end else if (nonce_cur == end_q) begin
                            state     <= S_EXHAUST;
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            // Natural 32-bit wrap lets end < start sweep through FFFFFFFF.
                            nonce_cur   <= nonce_nxt;
                            miner_block <= {header_q, bswap32(nonce_nxt)};
                            state       <= S_KICK;
                        end
                    end
                end

                default: begin
                    // IDLE and terminal states: start wins over abort, abort is a no-op here.
                    if (start) begin
                        header_q    <= header_in;
                        nonce_cur   <= nonce_start;
                        end_q       <= nonce_end;
                        target_q    <= target;
                        miner_block <= {header_in, bswap32(nonce_start)};
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_KICK;
`ifdef NONCE_SWEEP_HASHCNT_EN
                        hash_count  <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule
